uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk32 cycles per serial bit; legal values are even and >= 4.
REQ-002 SHALL have port clk32  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rx  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-005 SHALL have port rxdata  output  8  last correctly framed byte; held until the next good frame.
REQ-006 SHALL have port rx_enable  output  1  one-cycle pulse; rxdata is valid and newly updated in the same cycle.
REQ-007 SHALL have port framing_error  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-009 SHALL pass rx through a two-flop synchronizer; the second flop's output is rx_s, and all decisions use rx_s only.
REQ-010 SHALL implement the states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-011 In IDLE, rx_s==0 SHALL move the FSM to START and load the bit counter so the start sample occurs CLKS_PER_BIT/2 cycles later (mid-bit).
REQ-012 In START, the mid-bit sample SHALL be handled as follows:
- rx_s==1: false start; return to IDLE with no output pulse.
- rx_s==0: go to DATA with bit index 0.
REQ-013 In DATA, bit i (0..7) SHALL be sampled exactly (i+1)*CLKS_PER_BIT cycles after the start sample and shifted in LSB first.
REQ-014 After bit 7, the FSM SHALL go to STOP; the stop bit is sampled 9*CLKS_PER_BIT cycles after the start sample.
REQ-015 A stop sample of 1 SHALL load rxdata with the shift register and pulse rx_enable for exactly one cycle, asserted on the cycle after the stop sample; the FSM then enters IDLE.
REQ-016 A stop sample of 0 SHALL pulse framing_error for one cycle on the cycle after the stop sample, leave rxdata unchanged and enter WAIT_IDLE.
REQ-017 WAIT_IDLE SHALL remain until rx_s==1, then go to IDLE; a continuous low (break) SHALL NOT produce further pulses.
REQ-018 A falling edge arriving in the same cycle IDLE is entered after a good stop SHALL be detected; back-to-back frames SHALL be received with no gap cycles.
REQ-019 rx_enable and framing_error SHALL never be high in the same cycle.
REQ-020 The bit counter SHALL be sized ceil(log2(CLKS_PER_BIT)) bits and SHALL wrap only by explicit reload, never by overflow.
REQ-021 rx activity during a frame SHALL be ignored except at the defined sample instants.

Reset
REQ-022 reset SHALL force state IDLE, rxdata=8'h00, rx_enable=0, framing_error=0, busy=0, and counters and shift register to 0.
REQ-023 reset SHALL preset both synchronizer flops to 1, so that no false start is seen on release.
REQ-024 reset asserted mid-frame SHALL abort the frame with no output pulse; reception restarts on the next falling edge after release.

Verification
REQ-025 CLKS_PER_BIT=16, frame 0x55 at 16 cycles/bit -> rx_enable pulses once, one cycle long, rxdata=8'h55, busy low the following cycle.
REQ-026 Sweep bytes 0x00 through 0xFF back-to-back with no idle gap -> 256 rx_enable pulses in order with rxdata matching each byte, and zero framing_error pulses.
REQ-027 8-cycle low glitch on rx while idle -> no rx_enable pulse, no framing_error pulse, and busy returns low 11 cycles after the glitch begins (2 synchronizer + 8 + 1).
REQ-028 Frame 0xA3 with stop bit driven low, then rx held low for 40 bit times -> one framing_error pulse, rxdata unchanged; after rx returns high, the next 0x3C frame yields rxdata=8'h3C.
REQ-029 reset asserted during bit 4 of a 0xF0 frame, then a fresh 0x81 frame -> no pulse for the aborted frame, and rx_enable with rxdata=8'h81.
REQ-030 Transmitter running at ±3% baud error relative to CLKS_PER_BIT=16 -> all bytes 0x00..0x0F received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2x-synchronised input and mid-bit sampling.
//
// Ports:
//   clk32          in   1  system clock; all logic on its rising edge
//   reset          in   1  synchronous, active-high
//   rx             in   1  asynchronous serial line, idle high, LSB first
//   rxdata         out  8  last correctly framed byte, held until the next good frame
//   rx_enable      out  1  one-cycle pulse, rxdata newly updated in the same cycle
//   framing_error  out  1  one-cycle pulse when the stop bit is sampled low
//   busy           out  1  high whenever the receiver is not idle
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk32,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rxdata,
  output logic       rx_enable,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  logic          r_sync1;
  logic          r_rx_s;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_rxdata;
  logic          r_rx_enable;
  logic          r_framing_error;
  logic          r_busy;

  // Input synchroniser: presets high so reset release never looks like a start bit.
  always_ff @(posedge clk32) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
    end
  end

  // Receive FSM. r_cnt counts down to zero and is always explicitly reloaded,
  // so a sample happens on the cycle r_cnt is zero. Loading HALF_M1 on the
  // detecting edge puts the start sample CLKS_PER_BIT/2 cycles later.
  always_ff @(posedge clk32) begin
    if (reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_idx           <= '0;
      r_shift         <= '0;
      r_rxdata        <= '0;
      r_rx_enable     <= 1'b0;
      r_framing_error <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_rx_enable     <= 1'b0;
      r_framing_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_rx_s) begin
            r_state <= START;
            r_cnt   <= HALF_M1;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else if (r_rx_s) begin
            // Line back high at mid start bit: treat as a glitch.
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= DATA;
            r_cnt   <= BIT_M1;
            r_idx   <= '0;
          end
        end
        DATA: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_shift <= {r_rx_s, r_shift[7:1]};
            r_cnt   <= BIT_M1;
            if (r_idx == 3'd7) begin
              r_state <= STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else if (r_rx_s) begin
            // Returning to IDLE here lets a start bit that follows
            // immediately be caught on the very next edge.
            r_rxdata    <= r_shift;
            r_rx_enable <= 1'b1;
            r_state     <= IDLE;
            r_busy      <= 1'b0;
          end else begin
            r_framing_error <= 1'b1;
            r_state         <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          // A held-low line (break) parks here silently.
          if (r_rx_s) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rxdata        = r_rxdata;
  assign rx_enable     = r_rx_enable;
  assign framing_error = r_framing_error;
  assign busy          = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed testbench for uart_rx at CLKS_PER_BIT=16.
module tb_uart_rx;

  logic       clk32 = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] rxdata;
  logic       rx_enable;
  logic       framing_error;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(16)) dut (
    .clk32        (clk32),
    .reset        (reset),
    .rx           (rx),
    .rxdata       (rxdata),
    .rx_enable    (rx_enable),
    .framing_error(framing_error),
    .busy         (busy)
  );

  always #5 clk32 = ~clk32;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk32) cyc <= cyc + 1;

  // Event monitor: collects received bytes and pulse statistics.
  logic [7:0] rq[$];
  int   en_cnt = 0, fe_cnt = 0, both_cnt = 0, wide_cnt = 0, busy_after = 0;
  int   last_en_cyc = -1;
  logic prev_en = 1'b0;

  always @(negedge clk32) begin
    if (reset) begin
      prev_en = 1'b0;
    end else begin
      if (rx_enable) begin
        rq.push_back(rxdata);
        en_cnt++;
        last_en_cyc = cyc;
      end
      if (framing_error) fe_cnt++;
      if (rx_enable && framing_error) both_cnt++;
      if (rx_enable && prev_en) wide_cnt++;
      if (prev_en && busy) busy_after++;
      prev_en = rx_enable;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk32);
      #1;
    end
  endtask

  // Drives one 8N1 frame; per_x100 is the bit period in hundredths of a cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int per_x100);
    logic [9:0] fr;
    int n;
    int idx;
    fr  = {stop, d, 1'b0};
    n   = 0;
    idx = 0;
    while (idx < 10) begin
      rx = fr[idx];
      tick(1);
      n++;
      idx = (n * 100) / per_x100;
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic [7:0] exp_data;
    int         exp_en;
    int         exp_fe;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int b_en, b_fe, base, start_cyc, rise_k, fall_k;
    logic [9:0] fr;

    vecs[0] = '{d: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_en: 1, exp_fe: 0};
    vecs[1] = '{d: 8'hFF, stop: 1'b1, exp_data: 8'hFF, exp_en: 1, exp_fe: 0};
    vecs[2] = '{d: 8'hA5, stop: 1'b0, exp_data: 8'hFF, exp_en: 0, exp_fe: 1};
    vecs[3] = '{d: 8'h5A, stop: 1'b1, exp_data: 8'h5A, exp_en: 1, exp_fe: 0};
    vecs[4] = '{d: 8'h80, stop: 1'b1, exp_data: 8'h80, exp_en: 1, exp_fe: 0};
    vecs[5] = '{d: 8'h01, stop: 1'b0, exp_data: 8'h80, exp_en: 0, exp_fe: 1};
    vecs[6] = '{d: 8'hC3, stop: 1'b1, exp_data: 8'hC3, exp_en: 1, exp_fe: 0};

    // Reset state
    reset = 1'b1;
    rx    = 1'b1;
    tick(4);
    check("reset_rxdata", rxdata, 8'h00);
    check("reset_rx_enable", rx_enable, 0);
    check("reset_framing_error", framing_error, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    tick(4);
    check("release_busy", busy, 0);

    // 0x55 frame with exact pulse timing
    b_en      = en_cnt;
    start_cyc = cyc;
    send_frame(8'h55, 1'b1, 1600);
    tick(8);
    check("f55_pulses", en_cnt - b_en, 1);
    check("f55_rxdata", rxdata, 8'h55);
    check("f55_pulse_cycle", last_en_cyc - start_cyc, 155);
    check("f55_pulse_width", wide_cnt, 0);
    check("f55_busy_after_pulse", busy_after, 0);

    // Stop bit low followed by a long break
    b_en = en_cnt;
    b_fe = fe_cnt;
    send_frame(8'hA3, 1'b0, 1600);
    rx = 1'b0;
    tick(640);
    check("break_fe_pulses", fe_cnt - b_fe, 1);
    check("break_en_pulses", en_cnt - b_en, 0);
    check("break_rxdata_held", rxdata, 8'h55);
    check("break_busy", busy, 1);
    rx = 1'b1;
    tick(16);
    check("break_end_busy", busy, 0);
    send_frame(8'h3C, 1'b1, 1600);
    tick(8);
    check("after_break_pulses", en_cnt - b_en, 1);
    check("after_break_rxdata", rxdata, 8'h3C);

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      b_en = en_cnt;
      b_fe = fe_cnt;
      send_frame(vecs[i].d, vecs[i].stop, 1600);
      rx = 1'b1;
      tick(16);
      check($sformatf("vec%0d_en", i), en_cnt - b_en, vecs[i].exp_en);
      check($sformatf("vec%0d_fe", i), fe_cnt - b_fe, vecs[i].exp_fe);
      check($sformatf("vec%0d_rxdata", i), rxdata, vecs[i].exp_data);
      check($sformatf("vec%0d_busy", i), busy, 0);
    end

    // 8-cycle glitch while idle
    b_en   = en_cnt;
    b_fe   = fe_cnt;
    rise_k = -1;
    fall_k = -1;
    rx     = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      if (k == 8) rx = 1'b1;
      if (busy && rise_k < 0) rise_k = k;
      if (!busy && rise_k >= 0 && fall_k < 0) fall_k = k;
    end
    check("glitch_busy_rise", rise_k, 3);
    check("glitch_busy_fall", fall_k, 11);
    check("glitch_en", en_cnt - b_en, 0);
    check("glitch_fe", fe_cnt - b_fe, 0);

    // Reset during bit 4 of 0xF0
    b_en = en_cnt;
    b_fe = fe_cnt;
    fr   = {1'b1, 8'hF0, 1'b0};
    for (int n = 0; n < 88; n++) begin
      rx = fr[n / 16];
      tick(1);
    end
    reset = 1'b1;
    tick(2);
    rx    = 1'b1;
    reset = 1'b0;
    tick(20);
    check("abort_en", en_cnt - b_en, 0);
    check("abort_fe", fe_cnt - b_fe, 0);
    check("abort_busy", busy, 0);
    check("abort_rxdata", rxdata, 8'h00);
    send_frame(8'h81, 1'b1, 1600);
    tick(8);
    check("abort_next_en", en_cnt - b_en, 1);
    check("abort_next_rxdata", rxdata, 8'h81);

    // Back-to-back sweep 0x00..0xFF
    base = rq.size();
    b_fe = fe_cnt;
    for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1, 1600);
    tick(8);
    check("sweep_count", rq.size() - base, 256);
    check("sweep_fe", fe_cnt - b_fe, 0);
    for (int i = 0; i < 256; i++) begin
      if (base + i < rq.size()) check($sformatf("sweep_byte%0d", i), rq[base + i], i);
    end

    // +/-3% baud error
    for (int p = 0; p < 2; p++) begin
      int per;
      per  = (p == 0) ? 1648 : 1552;
      base = rq.size();
      b_fe = fe_cnt;
      for (int i = 0; i < 16; i++) begin
        send_frame(8'(i), 1'b1, per);
        rx = 1'b1;
        tick(16);
      end
      check($sformatf("baud%0d_count", per), rq.size() - base, 16);
      check($sformatf("baud%0d_fe", per), fe_cnt - b_fe, 0);
      for (int i = 0; i < 16; i++) begin
        if (base + i < rq.size()) check($sformatf("baud%0d_byte%0d", per, i), rq[base + i], i);
      end
    end

    // Global pulse properties
    check("never_both_pulses", both_cnt, 0);
    check("pulse_width_total", wide_cnt, 0);
    check("busy_after_pulse_total", busy_after, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
